mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side bus responder for the 6502 core. It is the other end of the decode unit's interface: it answers the core's address/RW/SYNC cycles by driving din and READY.
- Holds a single-port byte memory with a read-only upper region and a configurable wait-state generator (extra waits on opcode fetch).
- Has a bench/boot loader port for preloading programs.
- Sits between the CPU core and the top-level memory map; used in simulation and FPGA builds.

Parameters:
- ADDR_W, 12, memory index width; DEPTH = 2**ADDR_W bytes; addr[15:ADDR_W] ignored (mirroring).
- ROM_BASE, 12'hC00, first index (within ADDR_W space) of the read-only region; CPU writes at or above it are dropped.
- WAIT_CYCLES, 0, wait states inserted on every CPU read (0..15).
- FETCH_EXTRA, 1, additional wait states on reads with SYNC=1; WAIT_CYCLES+FETCH_EXTRA must be ≤15.

Ports:
- i_clk  in  1  clock, rising-edge.
- i_rst_n  in  1  asynchronous active-low reset.
- addr  in  16  CPU address.
- RW  in  1  1=read, 0=write.
- dout  in  8  CPU write data.
- SYNC  in  1  CPU opcode-fetch cycle.
- din  out  8  read data to CPU (registered).
- READY  out  1  1=cycle completes this edge; 0=CPU must hold addr/RW/SYNC.
- ld_en  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader index.
- ld_data  in  8  loader data.
- fetch_cnt  out  16  completed opcode fetches, wraps at 16'hFFFF→0.
- ro_err  out  1  sticky: CPU write attempted to ROM region.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE, wait counter=0, din=8'h00, fetch_cnt=0, ro_err=0; READY evaluates to 1 (unless ld_en=1).
  - Memory contents are not cleared.
- Index = addr[ADDR_W-1:0].
- States:
  - IDLE (no transaction in progress).
  - WAIT (read stalled, 4-bit counter cnt).
- Required waits for a read: W = WAIT_CYCLES + (SYNC ? FETCH_EXTRA : 0), computed in the first cycle of the transaction.
- READY (combinational from state, RW, SYNC, ld_en):
  - ld_en=1 → READY=0; no CPU access this cycle; state/cnt hold.
  - IDLE, RW=0 → READY=1.
  - IDLE, RW=1 → READY = (W==0).
  - WAIT → READY = (cnt==0).
- Transitions (ld_en=0):
  - IDLE, RW=1, W>0: enter WAIT, cnt ← W-1.
  - WAIT, cnt>0: cnt ← cnt-1.
  - WAIT, cnt==0: complete, go to IDLE.
- Read completion (any edge with READY=1, RW=1):
  - din ← mem[index], visible in the following cycle (1-cycle data latency; the core samples din the cycle after the completing cycle).
  - If SYNC=1, fetch_cnt ← fetch_cnt+1.
  - din holds its last value at all other times.
- Write (edge with READY=1, RW=0):
  - index < ROM_BASE → mem[index] ← dout.
  - Otherwise no write and ro_err ← 1.
  - Writes take zero wait states regardless of parameters; din unchanged.
- Loader (ld_en=1): mem[ld_addr] ← ld_data at the edge, ROM region included. Loader has priority; the CPU is stalled via READY=0.
- CPU changing addr/RW while READY=0 is a protocol violation. The responder uses the values present at the completing edge; W is not recomputed mid-transaction.
- Reset asserted mid-WAIT → IDLE immediately; a stalled read is abandoned with no din update.
- Back-to-back reads: a new transaction may start in the cycle after completion; no idle cycle required.

Test Plan:
- Preload via loader mem[0x000]=8'h69, mem[0x001]=8'h05; WAIT_CYCLES=0, FETCH_EXTRA=0; read 0x0000 with SYNC=1, then 0x0001 with SYNC=0 → READY stays 1; din=8'h69 one cycle after the first edge, then 8'h05; fetch_cnt=1.
- WAIT_CYCLES=2, FETCH_EXTRA=1, SYNC=1 read of 0x0000 → READY=0 for exactly 3 cycles, then 1; din=8'h69 the cycle after; fetch_cnt increments once. Same with SYNC=0 → 2 wait cycles.
- Write 8'hA5 to 0x0010, then read it back → one-cycle write, READY=1; read returns 8'hA5. Write 8'h11 to 0x0C00 → mem unchanged (reads old value), ro_err=1 and stays 1.
- Assert ld_en during a CPU read in IDLE → READY=0 while ld_en=1; read completes after ld_en drops and returns the loaded byte when ld_addr matches.
- Assert reset during the 2nd wait cycle (WAIT_CYCLES=3) → READY=1, din=8'h00, fetch_cnt=0 immediately; mem contents preserved on a subsequent read.
- Read address 0xF005 with ADDR_W=12 → returns mem[0x005] (mirroring); 65536 SYNC reads → fetch_cnt wraps to 0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side bus responder for the 6502 core.
//
// This block answers the core's address/RW/SYNC bus cycles. It contains a
// single-port byte memory whose upper region is read-only to the CPU, and a
// wait-state generator that can add extra waits on opcode fetches. A loader
// port lets a bench or boot ROM preload programs, including into the
// read-only region.
//
// Handshake: the CPU presents addr/RW/SYNC (and dout for writes) and holds
// them stable while READY=0. A bus cycle completes on the rising edge at
// which READY=1. For a read, din carries mem[index] from the cycle after the
// completing edge onward. While ld_en=1 the loader owns the memory and
// READY is forced low.
//
// Ports:
//   i_clk, i_rst_n  clock (rising edge), asynchronous active-low reset
//   addr[15:0]      CPU address; only addr[ADDR_W-1:0] is decoded (mirroring)
//   RW              1 = read, 0 = write
//   dout[7:0]       CPU write data
//   SYNC            CPU opcode-fetch cycle
//   din[7:0]        registered read data to the CPU
//   READY           1 = the current bus cycle completes at this edge
//   ld_en           loader write strobe (stalls the CPU)
//   ld_addr         loader memory index
//   ld_data         loader write data
//   fetch_cnt       completed opcode fetches, wraps at 16'hFFFF -> 0
//   ro_err          sticky flag: a CPU write targeted the read-only region
//   dbg_state       FSM state (0 = IDLE, 1 = WAIT)
module mem_responder #(
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] ROM_BASE    = 12'hC00,
  parameter int                WAIT_CYCLES = 0,
  parameter int                FETCH_EXTRA = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       addr,
  input  logic              RW,
  input  logic [7:0]        dout,
  input  logic              SYNC,
  output logic [7:0]        din,
  output logic              READY,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [15:0]       fetch_cnt,
  output logic              ro_err,
  output logic              dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_BASE = 4'(WAIT_CYCLES);
  localparam logic [3:0] WAIT_SYNC = 4'(FETCH_EXTRA);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [3:0]        need_waits;
  logic              rd_done;
  logic              wr_done;
  logic              wr_rom;
  logic              unused_addr_hi;

  // Upper address bits are deliberately ignored so the memory mirrors.
  assign idx            = addr[ADDR_W-1:0];
  assign unused_addr_hi = ^addr[15:ADDR_W];

  // Waits needed by a read; only consulted in IDLE, i.e. in the first cycle
  // of a transaction, so a SYNC change mid-stall cannot alter the count.
  assign need_waits = WAIT_BASE + (SYNC ? WAIT_SYNC : 4'd0);

  always_comb begin
    READY = 1'b0;
    if (ld_en) begin
      READY = 1'b0;
    end else if (state == IDLE) begin
      READY = RW ? (need_waits == 4'd0) : 1'b1;
    end else begin
      READY = (cnt == 4'd0);
    end
  end

  assign rd_done   = READY && RW;
  assign wr_done   = READY && !RW;
  assign wr_rom    = (idx >= ROM_BASE);
  assign dbg_state = state;

  // Control state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      din       <= 8'h00;
      fetch_cnt <= 16'h0000;
      ro_err    <= 1'b0;
    end else if (!ld_en) begin
      case (state)
        IDLE: begin
          if (RW && (need_waits != 4'd0)) begin
            state <= WAIT;
            cnt   <= need_waits - 4'd1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase

      if (rd_done) begin
        din <= mem[idx];
        if (SYNC) begin
          fetch_cnt <= fetch_cnt + 16'd1;
        end
      end

      if (wr_done && wr_rom) begin
        ro_err <= 1'b1;
      end
    end
  end

  // Memory array: no reset so contents survive i_rst_n. The loader wins over
  // the CPU; CPU writes are additionally blocked while reset is held so a
  // core sitting in reset cannot scribble on memory.
  always_ff @(posedge i_clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (i_rst_n && wr_done && !wr_rom) begin
      mem[idx] <= dout;
    end
  end

endmodule
